// File: rtl/mem_write_responder_if.sv
// Write-path stream bundle between the TCP stack and its memory responder.
// Carries the write command, write data and write status handshakes.
//   s_cmd_*  : command (start byte address, byte length)
//   s_data_* : data beats with byte enables and end-of-transfer marker
//   m_sts_*  : one 8-bit status word per command
// modport slave  : memory responder side
// modport master : stack side
interface mem_write_responder_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic                      s_cmd_valid;
  logic                      s_cmd_ready;
  logic [63:0]               s_cmd_address;
  logic [31:0]               s_cmd_length;
  logic                      s_data_valid;
  logic                      s_data_ready;
  logic [DATA_WIDTH-1:0]     s_data_data;
  logic [DATA_WIDTH/8-1:0]   s_data_keep;
  logic                      s_data_last;
  logic                      m_sts_valid;
  logic                      m_sts_ready;
  logic [7:0]                m_sts_data;

  modport slave (
    input  s_cmd_valid, s_cmd_address, s_cmd_length,
    input  s_data_valid, s_data_data, s_data_keep, s_data_last,
    input  m_sts_ready,
    output s_cmd_ready, s_data_ready, m_sts_valid, m_sts_data
  );

  modport master (
    output s_cmd_valid, s_cmd_address, s_cmd_length,
    output s_data_valid, s_data_data, s_data_keep, s_data_last,
    output m_sts_ready,
    input  s_cmd_ready, s_data_ready, m_sts_valid, m_sts_data
  );
endinterface

// File: rtl/mem_write_responder.sv
// Memory-side write responder: emulates an S2MM DataMover in front of an
// on-chip word memory. Accepts one write command, sinks its data beats into
// the memory, returns one status word, and keeps debug counters.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_if          : command/data/status streams (slave modport)
//   mem_*         : registered write port of the backing memory
//   cmd_count     : commands accepted
//   err_count     : status words sent with OKAY=0
//   byte_count    : sum of command lengths over OKAY transfers
module mem_write_responder #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned MEM_AW     = 14,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  mem_write_responder_if.slave    s_if,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [31:0]             cmd_count,
  output logic [31:0]             err_count,
  output logic [63:0]             byte_count
);
  localparam int unsigned BPB   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BPB);
  localparam int unsigned PTR_W = MEM_AW + 1;
  localparam logic [PTR_W-1:0] PTR_SAT = {1'b1, {MEM_AW{1'b0}}};
  localparam logic [63:0]      DEPTH64 = 64'(1) << MEM_AW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_STATUS = 2'd3;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_cmd_ptr;
  logic [31:0]      r_rem, w_rem_nxt, r_len;
  logic             r_len_err, w_len_err_nxt;
  logic             r_rng_err, w_rng_err_nxt;
  logic             w_wr_nxt;
  logic             r_cmd_ready, r_data_ready, r_sts_valid;
  logic [7:0]       r_sts_data;
  logic [63:0]      w_cmd_word;
  logic             w_cmd_hs, w_data_hs, w_sts_hs, w_rem_le;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_cmd_hs  = s_if.s_cmd_valid  && r_cmd_ready;
  assign w_data_hs = s_if.s_data_valid && r_data_ready;
  assign w_sts_hs  = r_sts_valid && s_if.m_sts_ready;
  assign w_rem_le  = (r_rem <= 32'(BPB));

  // Word pointer saturates one past the top so it never re-enters range
  assign w_cmd_word = (s_if.s_cmd_address - BASE_ADDR) >> OFF_W;
  assign w_cmd_ptr  = (w_cmd_word >= DEPTH64) ? PTR_SAT : w_cmd_word[PTR_W-1:0];

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_rem_nxt     = r_rem;
    w_len_err_nxt = r_len_err;
    w_rng_err_nxt = r_rng_err;
    w_wr_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_ptr_nxt     = w_cmd_ptr;
          w_rem_nxt     = s_if.s_cmd_length;
          w_rng_err_nxt = 1'b0;
          if (s_if.s_cmd_length == 32'd0) begin
            w_len_err_nxt = 1'b1;
            w_state_nxt   = ST_STATUS;
          end else begin
            w_len_err_nxt = 1'b0;
            w_state_nxt   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_data_hs) begin
          if (r_ptr[MEM_AW]) begin
            w_rng_err_nxt = 1'b1;
          end else begin
            w_wr_nxt  = 1'b1;
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
          w_rem_nxt = w_rem_le ? 32'd0 : (r_rem - 32'(BPB));
          if (s_if.s_data_last) begin
            if (!w_rem_le) w_len_err_nxt = 1'b1;
            w_state_nxt = ST_STATUS;
          end else if (w_rem_le) begin
            // Stream outlives the command length: swallow the excess
            w_len_err_nxt = 1'b1;
            w_state_nxt   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_data_hs && s_if.s_data_last) w_state_nxt = ST_STATUS;
      end
      ST_STATUS: begin
        if (w_sts_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, registered handshake outputs, memory port and counters
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_rem        <= '0;
      r_len        <= '0;
      r_len_err    <= 1'b0;
      r_rng_err    <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_sts_valid  <= 1'b0;
      r_sts_data   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      cmd_count    <= '0;
      err_count    <= '0;
      byte_count   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_rem        <= w_rem_nxt;
      r_len_err    <= w_len_err_nxt;
      r_rng_err    <= w_rng_err_nxt;
      r_cmd_ready  <= (w_state_nxt == ST_IDLE);
      r_data_ready <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_DRAIN);
      r_sts_valid  <= (w_state_nxt == ST_STATUS);
      r_sts_data   <= (w_state_nxt == ST_STATUS) ?
                      {~(w_len_err_nxt | w_rng_err_nxt), w_len_err_nxt, w_rng_err_nxt, 5'b0} :
                      8'h00;
      mem_we       <= w_wr_nxt;
      if (w_wr_nxt) begin
        mem_addr  <= r_ptr[MEM_AW-1:0];
        mem_wdata <= s_if.s_data_data;
        mem_wstrb <= s_if.s_data_keep;
      end
      if (w_cmd_hs) begin
        r_len     <= s_if.s_cmd_length;
        cmd_count <= cmd_count + 32'd1;
      end
      if (w_sts_hs) begin
        if (r_sts_data[7]) byte_count <= byte_count + 64'(r_len);
        else               err_count  <= err_count + 32'd1;
      end
    end
  end

  assign s_if.s_cmd_ready  = r_cmd_ready;
  assign s_if.s_data_ready = r_data_ready;
  assign s_if.m_sts_valid  = r_sts_valid;
  assign s_if.m_sts_data   = r_sts_data;
endmodule

// File: tb/tb_mem_write_responder.sv
`timescale 1ns/1ps
module tb_mem_write_responder;
  localparam int unsigned DW  = 512;
  localparam int unsigned AW  = 14;
  localparam int unsigned KW  = DW / 8;
  localparam int unsigned TMO = 50;

  logic          aclk;
  logic          aresetn;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [KW-1:0] mem_wstrb;
  logic [31:0]   cmd_count;
  logic [31:0]   err_count;
  logic [63:0]   byte_count;
  int            n_chk;
  int            n_fail;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [KW-1:0] strb;
    logic [63:0]   d;
  } wr_t;
  wr_t wq[$];

  mem_write_responder_if #(.DATA_WIDTH(DW)) bus ();

  mem_write_responder #(.DATA_WIDTH(DW), .MEM_AW(AW), .BASE_ADDR(64'h0)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_if(bus.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .cmd_count(cmd_count), .err_count(err_count), .byte_count(byte_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every memory write (mem_we is a one-cycle pulse per beat)
  always @(negedge aclk) begin
    if (mem_we === 1'b1) wq.push_back(wr_t'{mem_addr, mem_wstrb, mem_wdata[63:0]});
  end

  task automatic put_cmd(input logic [63:0] a, input logic [31:0] l, output bit ok);
    ok = 1'b0;
    bus.s_cmd_address = a; bus.s_cmd_length = l; bus.s_cmd_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge aclk);
      if (bus.s_cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge aclk); #1; end
    bus.s_cmd_valid = 1'b0;
  endtask

  task automatic put_beat(input logic [63:0] seed, input logic [KW-1:0] keep,
                          input logic last, output bit ok);
    ok = 1'b0;
    bus.s_data_data = {8{seed}}; bus.s_data_keep = keep; bus.s_data_last = last;
    bus.s_data_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge aclk);
      if (bus.s_data_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge aclk); #1; end
    bus.s_data_valid = 1'b0; bus.s_data_last = 1'b0;
  endtask

  task automatic wait_sts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (bus.m_sts_valid === 1'b1) begin ok = 1'b1; break; end
      @(posedge aclk); #1;
    end
  endtask

  task automatic ack_sts();
    bus.m_sts_ready = 1'b1;
    @(posedge aclk); #1;
    bus.m_sts_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_chk++;
    if ({bus.s_cmd_ready, bus.s_data_ready, bus.m_sts_valid, mem_we} !== 4'b0 ||
        bus.m_sts_data !== 8'h00 || cmd_count !== 32'd0 || err_count !== 32'd0 || byte_count !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: cmd_rdy=%b data_rdy=%b sts_v=%b we=%b cnt=%0d/%0d/%0d expected all 0",
               bus.s_cmd_ready, bus.s_data_ready, bus.m_sts_valid, mem_we, cmd_count, err_count, byte_count);
    end
    aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    n_chk++;
    if (bus.s_cmd_ready !== 1'b1 || bus.s_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: cmd_rdy=%b data_rdy=%b expected 1 0", bus.s_cmd_ready, bus.s_data_ready);
    end
  endtask

  task automatic test_exact();
    bit ok, a;
    wq.delete(); a = 1'b1;
    put_cmd(64'h0, 32'd128, ok); a &= ok;
    put_beat(64'h1111, '1, 1'b0, ok); a &= ok;
    put_beat(64'h2222, '1, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL exact_handshake: got %b expected 1", a); end
    n_chk++;
    if (bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h80) begin
      n_fail++; $display("FAIL exact_status: valid=%b data=%h expected 1 80", bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 2 && wq[0] === wr_t'{14'd0, {KW{1'b1}}, 64'h1111} &&
          wq[1] === wr_t'{14'd1, {KW{1'b1}}, 64'h2222})) begin
      n_fail++; $display("FAIL exact_writes: got %0d writes expected 2 at words 0,1", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd1 || byte_count !== 64'd128 || err_count !== 32'd0) begin
      n_fail++; $display("FAIL exact_counters: cmd=%0d byte=%0d err=%0d expected 1 128 0", cmd_count, byte_count, err_count);
    end
    n_chk++;
    if (bus.s_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL exact_cmd_ready: got %b expected 1", bus.s_cmd_ready); end
  endtask

  task automatic test_partial();
    bit ok, a;
    logic [KW-1:0] tail;
    tail = 64'h0000_000F_FFFF_FFFF;
    wq.delete(); a = 1'b1;
    put_cmd(64'h1000, 32'd100, ok); a &= ok;
    put_beat(64'h3333, '1, 1'b0, ok); a &= ok;
    put_beat(64'h4444, tail, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h80) begin
      n_fail++; $display("FAIL partial_status: hs=%b valid=%b data=%h expected 1 1 80", a, bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 2 && wq[0] === wr_t'{14'd64, {KW{1'b1}}, 64'h3333} &&
          wq[1] === wr_t'{14'd65, tail, 64'h4444})) begin
      n_fail++; $display("FAIL partial_writes: got %0d writes expected 2 at words 64,65", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd2 || byte_count !== 64'd228 || err_count !== 32'd0) begin
      n_fail++; $display("FAIL partial_counters: cmd=%0d byte=%0d err=%0d expected 2 228 0", cmd_count, byte_count, err_count);
    end
  endtask

  task automatic test_short();
    bit ok, a;
    wq.delete(); a = 1'b1;
    put_cmd(64'h2000, 32'd256, ok); a &= ok;
    put_beat(64'h5555, '1, 1'b0, ok); a &= ok;
    put_beat(64'h6666, '1, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h40) begin
      n_fail++; $display("FAIL short_status: hs=%b valid=%b data=%h expected 1 1 40", a, bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 2 && wq[0].addr === 14'd128 && wq[1].addr === 14'd129)) begin
      n_fail++; $display("FAIL short_writes: got %0d writes expected 2 at words 128,129", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd3 || byte_count !== 64'd228 || err_count !== 32'd1) begin
      n_fail++; $display("FAIL short_counters: cmd=%0d byte=%0d err=%0d expected 3 228 1", cmd_count, byte_count, err_count);
    end
  endtask

  task automatic test_long();
    bit ok, a;
    wq.delete(); a = 1'b1;
    put_cmd(64'h3000, 32'd64, ok); a &= ok;
    put_beat(64'h7777, '1, 1'b0, ok); a &= ok;
    put_beat(64'h8888, '1, 1'b0, ok); a &= ok;
    put_beat(64'h9999, '1, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h40) begin
      n_fail++; $display("FAIL long_status: hs=%b valid=%b data=%h expected 1 1 40", a, bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 1 && wq[0] === wr_t'{14'd192, {KW{1'b1}}, 64'h7777})) begin
      n_fail++; $display("FAIL long_writes: got %0d writes expected 1 at word 192", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd4 || byte_count !== 64'd228 || err_count !== 32'd2) begin
      n_fail++; $display("FAIL long_counters: cmd=%0d byte=%0d err=%0d expected 4 228 2", cmd_count, byte_count, err_count);
    end
  endtask

  task automatic test_range();
    bit ok, a;
    wq.delete(); a = 1'b1;
    put_cmd(64'h000F_FFC0, 32'd128, ok); a &= ok;
    put_beat(64'hAAAA, '1, 1'b0, ok); a &= ok;
    put_beat(64'hBBBB, '1, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h20) begin
      n_fail++; $display("FAIL range_status: hs=%b valid=%b data=%h expected 1 1 20", a, bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 1 && wq[0] === wr_t'{14'd16383, {KW{1'b1}}, 64'hAAAA})) begin
      n_fail++; $display("FAIL range_writes: got %0d writes expected 1 at word 16383", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd5 || byte_count !== 64'd228 || err_count !== 32'd3) begin
      n_fail++; $display("FAIL range_counters: cmd=%0d byte=%0d err=%0d expected 5 228 3", cmd_count, byte_count, err_count);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    wq.delete();
    put_cmd(64'h0, 32'd0, ok);
    bus.s_data_valid = 1'b1; bus.s_data_last = 1'b1;
    n_chk++;
    if (ok !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h40 || bus.s_data_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_status: hs=%b valid=%b data=%h data_rdy=%b expected 1 1 40 0",
                         ok, bus.m_sts_valid, bus.m_sts_data, bus.s_data_ready);
    end
    ack_sts();
    bus.s_data_valid = 1'b0; bus.s_data_last = 1'b0;
    n_chk++;
    if (wq.size() != 0 || cmd_count !== 32'd6 || err_count !== 32'd4 || byte_count !== 64'd228) begin
      n_fail++; $display("FAIL zero_counters: writes=%0d cmd=%0d err=%0d byte=%0d expected 0 6 4 228",
                         wq.size(), cmd_count, err_count, byte_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok, a;
    int bad;
    a = 1'b1; bad = 0;
    put_cmd(64'h0, 32'd64, ok); a &= ok;
    put_beat(64'hCCCC, '1, 1'b1, ok); a &= ok;
    wait_sts(ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_data !== 8'h80) begin
      n_fail++; $display("FAIL bp_status: hs=%b data=%h expected 1 80", a, bus.m_sts_data);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h80 || bus.s_cmd_ready !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    ack_sts();
    n_chk++;
    if (cmd_count !== 32'd7 || byte_count !== 64'd292 || err_count !== 32'd4 || bus.m_sts_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_counters: cmd=%0d byte=%0d err=%0d sts_v=%b expected 7 292 4 0",
                         cmd_count, byte_count, err_count, bus.m_sts_valid);
    end
  endtask

  task automatic test_reset_mid_data();
    bit ok, a;
    a = 1'b1;
    put_cmd(64'h0, 32'd128, ok); a &= ok;
    put_beat(64'hDDDD, '1, 1'b0, ok); a &= ok;
    aresetn = 1'b0;
    #1;
    n_chk++;
    if (a !== 1'b1 || {bus.s_cmd_ready, bus.s_data_ready, bus.m_sts_valid, mem_we} !== 4'b0 ||
        cmd_count !== 32'd0 || err_count !== 32'd0 || byte_count !== 64'd0) begin
      n_fail++; $display("FAIL midrst_outputs: hs=%b rdy=%b%b sts_v=%b we=%b cmd=%0d expected 1 00 0 0 0",
                         a, bus.s_cmd_ready, bus.s_data_ready, bus.m_sts_valid, mem_we, cmd_count);
    end
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    wq.delete(); a = 1'b1;
    put_cmd(64'h40, 32'd64, ok); a &= ok;
    put_beat(64'hEEEE, '1, 1'b1, ok); a &= ok;
    n_chk++;
    if (a !== 1'b1 || bus.m_sts_valid !== 1'b1 || bus.m_sts_data !== 8'h80) begin
      n_fail++; $display("FAIL midrst_status: hs=%b valid=%b data=%h expected 1 1 80", a, bus.m_sts_valid, bus.m_sts_data);
    end
    ack_sts();
    n_chk++;
    if (!(wq.size() == 1 && wq[0] === wr_t'{14'd1, {KW{1'b1}}, 64'hEEEE})) begin
      n_fail++; $display("FAIL midrst_writes: got %0d writes expected 1 at word 1", wq.size());
    end
    n_chk++;
    if (cmd_count !== 32'd1 || byte_count !== 64'd64 || err_count !== 32'd0) begin
      n_fail++; $display("FAIL midrst_counters: cmd=%0d byte=%0d err=%0d expected 1 64 0", cmd_count, byte_count, err_count);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    aresetn = 1'b0;
    bus.s_cmd_valid = 1'b0; bus.s_cmd_address = '0; bus.s_cmd_length = '0;
    bus.s_data_valid = 1'b0; bus.s_data_data = '0; bus.s_data_keep = '0; bus.s_data_last = 1'b0;
    bus.m_sts_ready = 1'b0;
    test_reset();
    test_exact();
    test_partial();
    test_short();
    test_long();
    test_range();
    test_zero_len();
    test_backpressure();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
